// File: rtl/tdc_peak_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_peak_buffer_if
// Description : Output stream bundle of the TDC peak buffer. It carries the
//               valid/ready/last handshake with the tof, intensity and
//               entry-count fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_peak_buffer_if #(
    parameter int TOF_W = 15,
    parameter int INT_W = 5,
    parameter int NUM_W = 2
);
    logic [TOF_W-1:0] TDC_Odata;
    logic [INT_W-1:0] TDC_Oint;
    logic [NUM_W-1:0] TDC_Onum;
    logic             TDC_Ovalid;
    logic             TDC_Olast;
    logic             TDC_Oready;

    // The producer (buffer) drives the beat and the consumer drives ready
    modport master (
        output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast,
        input  TDC_Oready
    );

    modport slave (
        input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast,
        output TDC_Oready
    );
endinterface
`default_nettype wire

// File: rtl/tdc_peak_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_peak_buffer
// Description : Keeps the DEPTH strongest TDC returns of a frame. When the
//               frame closes it streams them out with valid/ready/last and
//               then pulses a frame-done interrupt.
//               Optional build macro TDC_SORT_DESC_EN: drain in descending
//               intensity order (ties go to the lowest slot). When the macro
//               is absent, the drain follows slot order.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_peak_buffer #(
    parameter int TOF_W = 15,
    parameter int INT_W = 5,
    parameter int DEPTH = 3,
    parameter int NUM_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             ev_valid,
    input  wire logic [TOF_W-1:0] ev_tof,
    input  wire logic [INT_W-1:0] ev_int,
    input  wire logic             frame_end,
    tdc_peak_buffer_if.master     out_bus,
    output logic                  TDC_INT,
    output logic [7:0]            drop_cnt
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    // Registered state
    state_t           state;
    logic [TOF_W-1:0] slot_tof [DEPTH];
    logic [INT_W-1:0] slot_int [DEPTH];
    logic [NUM_W-1:0] count;
    logic [DEPTH-1:0] sent;      // entries already streamed this frame
    logic [NUM_W-1:0] left;      // beats still to send, including the current one
    logic [IDX_W-1:0] cur_sel;   // slot shown on the current beat
    logic [NUM_W-1:0] num_q;
    logic [7:0]       drop_q;
    logic             irq_q;
    logic [TOF_W-1:0] odata_q;
    logic [INT_W-1:0] oint_q;
    logic [NUM_W-1:0] onum_q;
    logic             ovalid_q;
    logic             olast_q;

    // Next-state values
    state_t           state_nxt;
    logic [TOF_W-1:0] tof_nxt [DEPTH];
    logic [INT_W-1:0] int_nxt [DEPTH];
    logic [NUM_W-1:0] count_nxt;
    logic [DEPTH-1:0] sent_nxt;
    logic [NUM_W-1:0] left_nxt;
    logic [NUM_W-1:0] num_nxt;
    logic [7:0]       drop_nxt;
    logic             irq_nxt;
    logic [IDX_W-1:0] min_idx;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic [TOF_W-1:0] odata_nxt;
    logic [INT_W-1:0] oint_nxt;
    logic [NUM_W-1:0] onum_nxt;
    logic             ovalid_nxt;
    logic             olast_nxt;

    // Weakest retained slot; strict compare keeps the lowest index on ties
    always_comb begin
        min_idx = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (slot_int[i] < slot_int[min_idx]) begin
                min_idx = IDX_W'(i);
            end
        end
    end

    // Frame collection and drain bookkeeping
    always_comb begin
        state_nxt = state;
        tof_nxt   = slot_tof;
        int_nxt   = slot_int;
        count_nxt = count;
        sent_nxt  = sent;
        left_nxt  = left;
        num_nxt   = num_q;
        drop_nxt  = drop_q;
        irq_nxt   = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (ev_valid) begin
                    if (count < NUM_W'(DEPTH)) begin
                        tof_nxt[IDX_W'(count)] = ev_tof;
                        int_nxt[IDX_W'(count)] = ev_int;
                        count_nxt              = count + 1'b1;
                    end else if (ev_int > slot_int[min_idx]) begin
                        tof_nxt[min_idx] = ev_tof;
                        int_nxt[min_idx] = ev_int;
                    end
                end
                // A coincident event is already folded into count_nxt
                if (frame_end) begin
                    state_nxt = ST_DRAIN;
                    left_nxt  = count_nxt;
                    num_nxt   = count_nxt;
                    sent_nxt  = '0;
                end
            end
            ST_DRAIN: begin
                if (ev_valid && (drop_q != 8'hFF)) begin
                    drop_nxt = drop_q + 8'd1;
                end
                // Valid is always high in DRAIN, so ready alone is the handshake
                if (out_bus.TDC_Oready) begin
                    if (left <= NUM_W'(1)) begin
                        state_nxt = ST_COLLECT;
                        for (int i = 0; i < DEPTH; i++) begin
                            tof_nxt[i] = '0;
                            int_nxt[i] = '0;
                        end
                        count_nxt = '0;
                        sent_nxt  = '0;
                        left_nxt  = '0;
                        num_nxt   = '0;
                        irq_nxt   = 1'b1;
                    end else begin
                        sent_nxt[cur_sel] = 1'b1;
                        left_nxt          = left - 1'b1;
                    end
                end
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

    // Choose the slot that the next beat presents, from the next-state view
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((NUM_W'(i) < count_nxt) && !sent_nxt[i]) begin
`ifdef TDC_SORT_DESC_EN
                if (!found || (int_nxt[i] > int_nxt[sel])) begin
                    sel   = IDX_W'(i);
                    found = 1'b1;
                end
`else
                if (!found) begin
                    sel   = IDX_W'(i);
                    found = 1'b1;
                end
`endif
            end
        end
    end

    // Beat contents for next cycle, so the outputs come straight from flops
    always_comb begin
        odata_nxt  = '0;
        oint_nxt   = '0;
        onum_nxt   = '0;
        ovalid_nxt = 1'b0;
        olast_nxt  = 1'b0;
        if (state_nxt == ST_DRAIN) begin
            ovalid_nxt = 1'b1;
            olast_nxt  = (left_nxt <= NUM_W'(1));
            onum_nxt   = num_nxt;
            if (found) begin
                odata_nxt = tof_nxt[sel];
                oint_nxt  = int_nxt[sel];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_COLLECT;
            for (int i = 0; i < DEPTH; i++) begin
                slot_tof[i] <= '0;
                slot_int[i] <= '0;
            end
            count    <= '0;
            sent     <= '0;
            left     <= '0;
            cur_sel  <= '0;
            num_q    <= '0;
            drop_q   <= '0;
            irq_q    <= 1'b0;
            odata_q  <= '0;
            oint_q   <= '0;
            onum_q   <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot_tof <= tof_nxt;
            slot_int <= int_nxt;
            count    <= count_nxt;
            sent     <= sent_nxt;
            left     <= left_nxt;
            cur_sel  <= sel;
            num_q    <= num_nxt;
            drop_q   <= drop_nxt;
            irq_q    <= irq_nxt;
            odata_q  <= odata_nxt;
            oint_q   <= oint_nxt;
            onum_q   <= onum_nxt;
            ovalid_q <= ovalid_nxt;
            olast_q  <= olast_nxt;
        end
    end

    assign out_bus.TDC_Odata  = odata_q;
    assign out_bus.TDC_Oint   = oint_q;
    assign out_bus.TDC_Onum   = onum_q;
    assign out_bus.TDC_Ovalid = ovalid_q;
    assign out_bus.TDC_Olast  = olast_q;
    assign TDC_INT            = irq_q;
    assign drop_cnt           = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_tdc_peak_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_peak_buffer
// Description : Self-checking bench for tdc_peak_buffer. A queue-based frame
//               model predicts every output cycle by cycle, and directed
//               scenarios pin the drained beats to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_peak_buffer;
    localparam int TOF_W = 15;
    localparam int INT_W = 5;
    localparam int DEPTH = 3;
    localparam int NUM_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ev_valid = 1'b0;
    logic [TOF_W-1:0] ev_tof = '0;
    logic [INT_W-1:0] ev_int = '0;
    logic             frame_end = 1'b0;
    logic             TDC_INT;
    logic [7:0]       drop_cnt;

    tdc_peak_buffer_if #(.TOF_W(TOF_W), .INT_W(INT_W), .NUM_W(NUM_W)) bus ();

    tdc_peak_buffer #(.TOF_W(TOF_W), .INT_W(INT_W), .DEPTH(DEPTH), .NUM_W(NUM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_valid  (ev_valid),
        .ev_tof    (ev_tof),
        .ev_int    (ev_int),
        .frame_end (frame_end),
        .out_bus   (bus),
        .TDC_INT   (TDC_INT),
        .drop_cnt  (drop_cnt)
    );

    always #2 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    typedef struct packed {
        logic [TOF_W-1:0] tof;
        logic [INT_W-1:0] itn;
    } ev_t;

    ev_t m_slots[$];
    ev_t m_beats[$];
    bit  m_drain = 1'b0;
    int  m_num   = 0;
    int  m_drop  = 0;
    bit  m_irq   = 1'b0;

    always @(posedge clk) begin
        int  mi;
        int  p;
        ev_t e;
        m_irq = 1'b0;
        if (rst) begin
            m_drain = 1'b0;
            m_slots = {};
            m_beats = {};
            m_num   = 0;
            m_drop  = 0;
        end else if (!m_drain) begin
            if (ev_valid) begin
                e.tof = ev_tof;
                e.itn = ev_int;
                if (m_slots.size() < DEPTH) begin
                    m_slots.push_back(e);
                end else begin
                    mi = 0;
                    for (int i = 1; i < m_slots.size(); i++)
                        if (m_slots[i].itn < m_slots[mi].itn) mi = i;
                    if (ev_int > m_slots[mi].itn) m_slots[mi] = e;
                end
            end
            if (frame_end) begin
                m_beats = {};
`ifdef TDC_SORT_DESC_EN
                foreach (m_slots[i]) begin
                    p = m_beats.size();
                    for (int j = 0; j < m_beats.size(); j++) begin
                        if (m_beats[j].itn < m_slots[i].itn) begin
                            p = j;
                            break;
                        end
                    end
                    m_beats.insert(p, m_slots[i]);
                end
`else
                m_beats = m_slots;
`endif
                m_num = m_slots.size();
                if (m_beats.size() == 0) m_beats.push_back('0);
                m_drain = 1'b1;
            end
        end else begin
            if (ev_valid && m_drop < 255) m_drop++;
            if (bus.TDC_Oready) begin
                void'(m_beats.pop_front());
                if (m_beats.size() == 0) begin
                    m_drain = 1'b0;
                    m_slots = {};
                    m_num   = 0;
                    m_irq   = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", bus.TDC_Ovalid, m_drain);
            chk("irq", TDC_INT, m_irq);
            chk("drop", drop_cnt, m_drop);
            if (m_drain) begin
                chk("data", bus.TDC_Odata, m_beats[0].tof);
                chk("int", bus.TDC_Oint, m_beats[0].itn);
                chk("num", bus.TDC_Onum, m_num);
                chk("last", bus.TDC_Olast, m_beats.size() == 1);
            end
        end
    end

    // Log of accepted beats for the literal checks
    typedef struct {
        int tof;
        int itn;
        int num;
        int last;
    } beat_t;
    beat_t blog[$];

    always @(negedge clk) begin
        beat_t b;
        if (cmp_en && !rst && bus.TDC_Ovalid && bus.TDC_Oready) begin
            b.tof  = bus.TDC_Odata;
            b.itn  = bus.TDC_Oint;
            b.num  = bus.TDC_Onum;
            b.last = bus.TDC_Olast;
            blog.push_back(b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ev(input int tof, input int itn);
        ev_valid = 1'b1;
        ev_tof   = TOF_W'(tof);
        ev_int   = INT_W'(itn);
        cyc();
        ev_valid = 1'b0;
    endtask

    task automatic close_frame();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
    endtask

    task automatic wait_irq();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (TDC_INT) seen = 1'b1;
        end
        chk("irq_seen", seen, 1);
        cyc();
    endtask

    task automatic chk_beat(input string name, input int idx,
                            input int tof, input int itn, input int num, input int last);
        if (idx >= blog.size()) begin
            chk({name, "_present"}, blog.size(), idx + 1);
        end else begin
            chk({name, "_tof"}, blog[idx].tof, tof);
            chk({name, "_int"}, blog[idx].itn, itn);
            chk({name, "_num"}, blog[idx].num, num);
            chk({name, "_last"}, blog[idx].last, last);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, bus.TDC_Ovalid, 0);
        chk({name, "_data"}, bus.TDC_Odata, 0);
        chk({name, "_int"}, bus.TDC_Oint, 0);
        chk({name, "_num"}, bus.TDC_Onum, 0);
        chk({name, "_last"}, bus.TDC_Olast, 0);
        chk({name, "_irq"}, TDC_INT, 0);
        chk({name, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        bus.TDC_Oready = 1'b1;
        rst = 1'b1;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk_idle("reset");
        rst = 1'b0;

        // Two events, ready high
        blog = {};
        send_ev(100, 3);
        send_ev(200, 7);
        close_frame();
        wait_irq();
        chk("two_beats", blog.size(), 2);
`ifdef TDC_SORT_DESC_EN
        chk_beat("two_b0", 0, 200, 7, 2, 0);
        chk_beat("two_b1", 1, 100, 3, 2, 1);
`else
        chk_beat("two_b0", 0, 100, 3, 2, 0);
        chk_beat("two_b1", 1, 200, 7, 2, 1);
`endif

        // Replacement: 5,2,9 fill; 4 evicts 2; final 2 rejected
        blog = {};
        send_ev(10, 5);
        send_ev(20, 2);
        send_ev(30, 9);
        send_ev(40, 4);
        send_ev(50, 2);
        close_frame();
        wait_irq();
        chk("repl_beats", blog.size(), 3);
`ifdef TDC_SORT_DESC_EN
        chk_beat("repl_b0", 0, 30, 9, 3, 0);
        chk_beat("repl_b1", 1, 10, 5, 3, 0);
        chk_beat("repl_b2", 2, 40, 4, 3, 1);
`else
        chk_beat("repl_b0", 0, 10, 5, 3, 0);
        chk_beat("repl_b1", 1, 40, 4, 3, 0);
        chk_beat("repl_b2", 2, 30, 9, 3, 1);
`endif

        // Empty frame
        blog = {};
        close_frame();
        wait_irq();
        chk("empty_beats", blog.size(), 1);
        chk_beat("empty_b0", 0, 0, 0, 0, 1);

        // Back-pressure with events dropped in DRAIN
        blog = {};
        send_ev(1, 1);
        send_ev(2, 2);
        bus.TDC_Oready = 1'b0;
        close_frame();
        for (int k = 0; k < 4; k++) begin
            ev_valid = (k < 3);
            ev_tof   = TOF_W'(300 + k);
            ev_int   = INT_W'(15);
            chk("stall_valid", bus.TDC_Ovalid, 1);
`ifdef TDC_SORT_DESC_EN
            chk("stall_data", bus.TDC_Odata, 2);
`else
            chk("stall_data", bus.TDC_Odata, 1);
`endif
            chk("stall_last", bus.TDC_Olast, 0);
            cyc();
        end
        ev_valid = 1'b0;
        chk("stall_drop", drop_cnt, 3);
        bus.TDC_Oready = 1'b1;
        wait_irq();
        chk("stall_beats", blog.size(), 2);

        // Event coincident with frame_end
        blog = {};
        ev_valid  = 1'b1;
        ev_tof    = TOF_W'(50);
        ev_int    = INT_W'(6);
        frame_end = 1'b1;
        cyc();
        ev_valid  = 1'b0;
        frame_end = 1'b0;
        wait_irq();
        chk("coinc_beats", blog.size(), 1);
        chk_beat("coinc_b0", 0, 50, 6, 1, 1);

        // Reset in the middle of a drain
        send_ev(7, 7);
        send_ev(8, 8);
        send_ev(9, 9);
        bus.TDC_Oready = 1'b0;
        close_frame();
        cyc();
        rst = 1'b1;
        cyc();
        chk_idle("midrst");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        blog = {};
        bus.TDC_Oready = 1'b1;
        send_ev(11, 1);
        close_frame();
        wait_irq();
        chk("post_beats", blog.size(), 1);
        chk_beat("post_b0", 0, 11, 1, 1, 1);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
